dmem_arbiter: RTL and testbench

//  Shares the single-port data_memory (sync write on CLK rising edge, combinational read) between two requesters:

---
 rtl/dmem_arb_pkg.sv | 21 ++
 rtl/rr_arb2.sv | 37 +++
 rtl/dmem_arbiter.sv | 142 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arb_pkg
//  Description : Shared types and constants for the data-memory arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
package dmem_arb_pkg;

    // Arbiter FSM encoding
    typedef enum logic [1:0] {
        ST_ARB   = 2'd0,
        ST_LOCK0 = 2'd1,
        ST_LOCK1 = 2'd2
    } arb_state_t;

    localparam int c_port_core = 0;   // core load/store unit
    localparam int c_port_load = 1;   // program loader / debug
    localparam int c_xlen      = 32;

endpackage : dmem_arb_pkg
`default_nettype wire

// File: rtl/rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : rr_arb2
//  Description : Two-way round-robin pick with lock override (combinational).
//  Revision    : 1.0  initial release
// ============================================================================
module rr_arb2
    import dmem_arb_pkg::*;
(
    input  arb_state_t state,
    input  logic       req0,
    input  logic       req1,
    input  logic       last,
    output logic       gnt0,
    output logic       gnt1
);

    // A held lock wins while its owner keeps requesting; otherwise the port
    // that was not served last wins a tie.
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if ((state == ST_LOCK0) && req0) begin
            gnt0 = 1'b1;
        end else if ((state == ST_LOCK1) && req1) begin
            gnt1 = 1'b1;
        end else if (req0 && req1) begin
            gnt0 = last;
            gnt1 = ~last;
        end else begin
            gnt0 = req0;
            gnt1 = req1;
        end
    end

endmodule : rr_arb2
`default_nettype wire

// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : dmem_arbiter
//  Description : Shares the single-port data memory between the core LSU and
//                the loader/debug port; round-robin with lock, bounds check,
//                registered read responses.
//  Revision    : 1.0  initial release
// ============================================================================
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DEPTH      = 64,
    parameter int ADDR_CHECK = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [c_xlen-1:0] a0,
    input  logic [c_xlen-1:0] a1,
    input  logic [c_xlen-1:0] wd0,
    input  logic [c_xlen-1:0] wd1,
    input  logic              lock0,
    input  logic              lock1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [c_xlen-1:0] rd0,
    output logic [c_xlen-1:0] rd1,
    output logic              err,
    output logic              mem_we,
    output logic [c_xlen-1:0] mem_a,
    output logic [c_xlen-1:0] mem_wd,
    input  logic [c_xlen-1:0] mem_rd
);

    localparam logic [c_xlen-3:0] c_depth = (c_xlen-2)'(DEPTH);

    arb_state_t        r_state;
    arb_state_t        w_state_next;
    logic              r_last;
    logic              w_pick0;
    logic              w_pick1;
    logic              w_gnt0;
    logic              w_gnt1;
    logic              w_any;
    logic [c_xlen-1:0] w_addr;
    logic              w_in_range;
    logic              w_rd0;
    logic              w_rd1;

    logic              r_rvalid0;
    logic              r_rvalid1;
    logic [c_xlen-1:0] r_rd0;
    logic [c_xlen-1:0] r_rd1;
    logic              r_err;

    rr_arb2 u_rr_arb2 (
        .state (r_state),
        .req0  (req0),
        .req1  (req1),
        .last  (r_last),
        .gnt0  (w_pick0),
        .gnt1  (w_pick1)
    );

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_ARB;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Grants (killed during reset so no access leaks out) and next lock state
    always_comb begin
        w_gnt0       = w_pick0 & ~rst;
        w_gnt1       = w_pick1 & ~rst;
        w_state_next = ST_ARB;
        if (w_gnt0 && lock0) begin
            w_state_next = ST_LOCK0;
        end else if (w_gnt1 && lock1) begin
            w_state_next = ST_LOCK1;
        end
    end

    // Memory-side mux; idle cycles drive zeros so the bus is quiet
    always_comb begin
        w_any  = w_gnt0 | w_gnt1;
        w_addr = w_gnt1 ? a1 : a0;
        w_in_range = (ADDR_CHECK == 0) || (w_addr[c_xlen-1:2] < c_depth);
        w_rd0  = w_gnt0 & ~we0;
        w_rd1  = w_gnt1 & ~we1;
        mem_we = ((w_gnt0 & we0) | (w_gnt1 & we1)) & w_in_range;
        mem_a  = w_any ? w_addr : '0;
        mem_wd = w_gnt1 ? wd1 : (w_gnt0 ? wd0 : '0);
    end

    // Remember who was served last; idle cycles leave it alone
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last <= 1'(c_port_load);
        end else if (w_any) begin
            r_last <= w_gnt1;
        end
    end

    // Registered read responses and out-of-range error pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rvalid0 <= 1'b0;
            r_rvalid1 <= 1'b0;
            r_rd0     <= '0;
            r_rd1     <= '0;
            r_err     <= 1'b0;
        end else begin
            r_rvalid0 <= w_rd0;
            r_rvalid1 <= w_rd1;
            if (w_rd0) begin
                r_rd0 <= w_in_range ? mem_rd : '0;
            end
            if (w_rd1) begin
                r_rd1 <= w_in_range ? mem_rd : '0;
            end
            r_err <= w_any & ~w_in_range;
        end
    end

    assign gnt0    = w_gnt0;
    assign gnt1    = w_gnt1;
    assign rvalid0 = r_rvalid0;
    assign rvalid1 = r_rvalid1;
    assign rd0     = r_rd0;
    assign rd1     = r_rd1;
    assign err     = r_err;

endmodule : dmem_arbiter
`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dmem_arbiter
//  Description : Self-checking bench for dmem_arbiter with a behavioural
//                data memory and reference model.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] a0, a1, wd0, wd1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err, mem_we;
    logic [31:0] rd0, rd1, mem_a, mem_wd, mem_rd;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.DEPTH(64), .ADDR_CHECK(1)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .a0(a0), .a1(a1), .wd0(wd0), .wd1(wd1),
        .lock0(lock0), .lock1(lock1),
        .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
        .rd0(rd0), .rd1(rd1), .err(err),
        .mem_we(mem_we), .mem_a(mem_a), .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    // data_memory: sync write, combinational read
    logic [31:0] dmem [64] = '{default: 32'h0};
    assign mem_rd = (mem_a[31:2] < 30'd64) ? dmem[mem_a[7:2]] : 32'h0;
    always @(posedge clk) begin
        if (mem_we && (mem_a[31:2] < 30'd64)) dmem[mem_a[7:2]] <= mem_wd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [64] = '{default: 32'h0};
    int          m_owner;          // -1 no lock, else port holding the lock
    logic        m_last;
    logic        m_rv0, m_rv1, m_err;
    logic [31:0] m_rd0, m_rd1;
    int          m_g;              // -1 idle, else granted port
    logic [31:0] m_addr, m_wd;
    logic        m_inr, m_we;

    function automatic int pick(input int owner, input logic last,
                                input logic r0, input logic r1);
        if (owner == 0 && r0) return 0;
        if (owner == 1 && r1) return 1;
        if (r0 && r1) return last ? 0 : 1;
        if (r0) return 0;
        if (r1) return 1;
        return -1;
    endfunction

    assign m_g    = pick(m_owner, m_last, req0, req1);
    assign m_addr = (m_g == 1) ? a1 : a0;
    assign m_wd   = (m_g == 1) ? wd1 : wd0;
    assign m_inr  = (m_addr / 4) < 64;
    assign m_we   = (m_g == 0) ? we0 : we1;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_owner <= -1;
            m_last  <= 1'b1;
            m_rv0   <= 1'b0;
            m_rv1   <= 1'b0;
            m_rd0   <= 32'h0;
            m_rd1   <= 32'h0;
            m_err   <= 1'b0;
        end else begin
            m_rv0 <= (m_g == 0) && !we0;
            m_rv1 <= (m_g == 1) && !we1;
            if (m_g == 0 && !we0) m_rd0 <= m_inr ? ref_mem[m_addr[7:2]] : 32'h0;
            if (m_g == 1 && !we1) m_rd1 <= m_inr ? ref_mem[m_addr[7:2]] : 32'h0;
            m_err <= (m_g >= 0) && !m_inr;
            if (m_g >= 0 && m_we && m_inr) ref_mem[m_addr[7:2]] <= m_wd;
            if (m_g >= 0) m_last <= (m_g == 1);
            m_owner <= (m_g == 0 && lock0) ? 0 : ((m_g == 1 && lock1) ? 1 : -1);
        end
    end

    // Per-cycle comparison against the model
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_gnt", {30'h0, gnt1, gnt0}, 32'h0);
            chk("rst_resp", {29'h0, rvalid1, rvalid0, err}, 32'h0);
            chk("rst_rd", rd0 | rd1, 32'h0);
            chk("rst_mem", {31'h0, mem_we} | mem_a | mem_wd, 32'h0);
        end else begin
            chk("gnt0", {31'h0, gnt0}, {31'h0, m_g == 0});
            chk("gnt1", {31'h0, gnt1}, {31'h0, m_g == 1});
            chk("mem_we", {31'h0, mem_we}, {31'h0, (m_g >= 0) && m_we && m_inr});
            chk("mem_a", mem_a, (m_g >= 0) ? m_addr : 32'h0);
            chk("mem_wd", mem_wd, (m_g >= 0) ? m_wd : 32'h0);
            chk("rvalid0", {31'h0, rvalid0}, {31'h0, m_rv0});
            chk("rvalid1", {31'h0, rvalid1}, {31'h0, m_rv1});
            chk("rd0", rd0, m_rd0);
            chk("rd1", rd1, m_rd1);
            chk("err", {31'h0, err}, {31'h0, m_err});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
    endtask

    // Directed stimulus with hand-computed expectations
    initial begin
        rst = 1; idle();
        a0 = 0; a1 = 0; wd0 = 0; wd1 = 0;
        repeat (2) @(posedge clk);
        #1 rst = 0;

        // 1: write via port 1, read back via port 0
        req1 = 1; we1 = 1; a1 = 32'h10; wd1 = 32'hCAFE;
        @(negedge clk); chk("t1_gnt1", {31'h0, gnt1}, 32'h1);
        step(); idle(); req0 = 1; a0 = 32'h10;
        @(negedge clk); chk("t1_gnt0", {31'h0, gnt0}, 32'h1);
        step(); idle();
        @(negedge clk);
        chk("t1_rvalid0", {31'h0, rvalid0}, 32'h1);
        chk("t1_rd0", rd0, 32'hCAFE);
        step();

        // 2: contended reads after reset alternate 0,1,0,1
        rst = 1; step(); rst = 0;
        req0 = 1; req1 = 1; a0 = 32'h10; a1 = 32'h14;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("t2_gnt0", {31'h0, gnt0}, (i % 2 == 0) ? 32'h1 : 32'h0);
            chk("t2_gnt1", {31'h0, gnt1}, (i % 2 == 1) ? 32'h1 : 32'h0);
            if (i == 1) chk("t2_rd0", rd0, 32'hCAFE);
            step();
        end
        idle();
        @(negedge clk);
        chk("t2_rvalid1", {31'h0, rvalid1}, 32'h1);
        chk("t2_rvalid0", {31'h0, rvalid0}, 32'h0);
        step();

        // 3: locked burst on port 1 holds off port 0
        for (int i = 0; i < 4; i++) begin
            req1 = 1; we1 = 1; lock1 = (i < 3); a1 = 32'(i * 4); wd1 = 32'(i + 3);
            req0 = (i > 0); we0 = 0; a0 = 32'h0;
            @(negedge clk);
            chk("t3_gnt1", {31'h0, gnt1}, 32'h1);
            chk("t3_gnt0", {31'h0, gnt0}, 32'h0);
            step();
        end
        req1 = 0; we1 = 0; lock1 = 0;
        for (int i = 0; i < 5; i++) begin
            if (i < 4) a0 = 32'(i * 4); else req0 = 0;
            @(negedge clk);
            if (i < 4) chk("t3_gnt0_after", {31'h0, gnt0}, 32'h1);
            if (i > 0) chk("t3_readback", rd0, 32'(i + 2));
            step();
        end

        // 4: out-of-range read
        req0 = 1; we0 = 0; a0 = 32'h100;
        @(negedge clk); chk("t4_gnt0", {31'h0, gnt0}, 32'h1);
        step(); idle();
        @(negedge clk);
        chk("t4_err", {31'h0, err}, 32'h1);
        chk("t4_rvalid0", {31'h0, rvalid0}, 32'h1);
        chk("t4_rd0", rd0, 32'h0);
        step();

        // 5: out-of-range write is suppressed
        req0 = 1; we0 = 1; a0 = 32'h200; wd0 = 32'hDEAD;
        @(negedge clk); chk("t5_mem_we", {31'h0, mem_we}, 32'h0);
        step(); idle();
        @(negedge clk);
        chk("t5_err", {31'h0, err}, 32'h1);
        chk("t5_word0", dmem[0], 32'h3);
        step();

        // 6: reset in the middle of a locked write burst
        req0 = 1; we0 = 1; lock0 = 1; a0 = 32'h20; wd0 = 32'h1111;
        @(negedge clk); chk("t6_gnt0_a", {31'h0, gnt0}, 32'h1);
        step();
        a0 = 32'h24; wd0 = 32'h2222; req1 = 1;
        @(negedge clk); chk("t6_gnt0_lock", {31'h0, gnt0}, 32'h1);
        #1 rst = 1;
        #1;
        chk("t6_gnt_rst", {30'h0, gnt1, gnt0}, 32'h0);
        chk("t6_we_rst", {31'h0, mem_we}, 32'h0);
        chk("t6_resp_rst", {29'h0, rvalid1, rvalid0, err}, 32'h0);
        step(); rst = 0;
        chk("t6_word8", dmem[8], 32'h1111);
        chk("t6_word9", dmem[9], 32'h0);
        we0 = 0; lock0 = 0; a0 = 32'h20; a1 = 32'h24; req0 = 1; req1 = 1;
        @(negedge clk);
        chk("t6_tie_gnt0", {31'h0, gnt0}, 32'h1);
        step();
        @(negedge clk);
        chk("t6_tie_gnt1", {31'h0, gnt1}, 32'h1);
        step(); idle();
        step();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1);
    end

endmodule : tb_dmem_arbiter
`default_nettype wire
